axi4_frame_buffer_writer: RTL and testbench

Parametrised stream-to-memory-mapped frame writer. Accepts pixel beats from the mixer path on a valid/ready stream, buffers them in an internal single-clock FIFO, and writes each frame to DDR through an AXI4 write master using INCR bursts. It extends the single-buffer writer with generic data width, burst length and frame size, a short final burst, a 1-to-4 frame-buffer ring, and start-of-frame resynchronisation. It sits between the chroma-key mixer and the PS DDR port; the HDMI reader consumes `last_buf_idx`.

---
 rtl/axi4_frame_buffer_writer.sv | 236 +++++++++++++++++++++++
 tb/tb_axi4_frame_buffer_writer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_frame_buffer_writer.sv
// Stream-to-memory frame writer: buffers pixel beats in a FIFO and writes each
// frame to DDR through an AXI4 write master using INCR bursts. The last burst of
// a frame is shortened, and frames rotate through a ring of NUM_BUF buffers.
// Ports:
//   clk_100Mhz, rst_n            - clock, async active-low reset
//   base_addr, enable            - buffer-0 base (4 KiB aligned), frame start enable
//   s_data/s_valid/s_sof/s_ready - input pixel stream
//   AW*/W*/B*                    - AXI4 write address/data/response channels
//   wr_buf_idx, last_buf_idx     - buffer being written / most recently completed
//   frame_valid, frame_done      - a frame exists since reset / completion pulse
//   bresp_err, sof_err           - sticky error flags
module axi4_frame_buffer_writer #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned BURST_LEN   = 64,
   parameter int unsigned FRAME_BYTES = 153600,
   parameter int unsigned NUM_BUF     = 3,
   parameter int unsigned BUF_STRIDE  = 32'h0004_0000,
   parameter int unsigned FIFO_DEPTH  = 256
) (
   input  logic                  clk_100Mhz,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic                  enable,
   input  logic [DATA_W-1:0]     s_data,
   input  logic                  s_valid,
   input  logic                  s_sof,
   output logic                  s_ready,
   output logic [ADDR_W-1:0]     AWADDR,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [7:0]            AWLEN,
   output logic [2:0]            AWSIZE,
   output logic [1:0]            AWBURST,
   output logic [3:0]            AWCACHE,
   output logic [2:0]            AWPROT,
   output logic [DATA_W-1:0]     WDATA,
   output logic [DATA_W/8-1:0]   WSTRB,
   output logic                  WVALID,
   input  logic                  WREADY,
   output logic                  WLAST,
   input  logic                  BVALID,
   output logic                  BREADY,
   input  logic [1:0]            BRESP,
   output logic [1:0]            wr_buf_idx,
   output logic [1:0]            last_buf_idx,
   output logic                  frame_valid,
   output logic                  frame_done,
   output logic                  bresp_err,
   output logic                  sof_err
);

   localparam int unsigned BYTES       = DATA_W / 8;
   localparam int unsigned FRAME_BEATS = FRAME_BYTES * 8 / DATA_W;
   localparam int unsigned CNT_W       = $clog2(FRAME_BEATS + 1);
   localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
   localparam int unsigned LW0         = (CNT_W > PTR_W + 1) ? CNT_W : PTR_W + 1;
   localparam int unsigned LW          = (LW0 > 9) ? LW0 : 9;
   localparam int unsigned PEND_W      = 8;

   typedef enum logic       {IN_SYNC, IN_FILL} in_state_t;
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} out_state_t;

   assign AWSIZE  = 3'($clog2(BYTES));
   assign AWBURST = 2'b01;
   assign AWCACHE = 4'b0011;
   assign AWPROT  = 3'b000;
   assign WSTRB   = '1;
   assign BREADY  = 1'b1;

   in_state_t             in_state, in_next;
   out_state_t            out_state, out_next;
   logic [DATA_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [PTR_W:0]        fifo_count;
   logic                  fifo_full, push_c, pop_c, sof_start_c;
   logic [CNT_W-1:0]      in_cnt, out_cnt;
   logic [ADDR_W-1:0]     in_base, out_base, base_sel_c, awaddr_c;
   logic [PEND_W-1:0]     pending;
   logic [LW-1:0]         rem_c, blen_c, cur_blen, beat_cnt;
   logic                  launch_c, frame_end_c;
   logic [1:0]            next_buf_c;

   // FIFO storage and occupancy
   assign fifo_full = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
   assign pop_c     = WVALID & WREADY & (fifo_count != '0);
   assign WDATA     = mem[rd_ptr];

   always_ff @(posedge clk_100Mhz)
      if (push_c) mem[wr_ptr] <= s_data;

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

   // Input side: discard until an enabled SOF, then take exactly one frame
   always_comb begin
      in_next = in_state;
      push_c  = 1'b0;
      s_ready = 1'b1;
      case (in_state)
         IN_SYNC: begin
            push_c = s_valid & s_sof & enable & ~fifo_full;
            if (push_c) in_next = (FRAME_BEATS == 1) ? IN_SYNC : IN_FILL;
         end
         IN_FILL: begin
            s_ready = ~fifo_full;
            push_c  = s_valid & ~fifo_full;
            if (push_c && in_cnt == CNT_W'(FRAME_BEATS - 1)) in_next = IN_SYNC;
         end
         default: in_next = IN_SYNC;
      endcase
   end

   assign sof_start_c = (in_state == IN_SYNC) & push_c;

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         in_state <= IN_SYNC;
         in_cnt   <= '0;
         in_base  <= '0;
         sof_err  <= 1'b0;
      end else begin
         in_state <= in_next;
         if (sof_start_c) begin
            in_base <= base_addr;
            in_cnt  <= CNT_W'(1);
         end else if (push_c) begin
            in_cnt <= in_cnt + CNT_W'(1);
            if (s_sof) sof_err <= 1'b1;
         end
      end
   end

   // Output side burst sizing and address generation
   assign rem_c       = LW'(FRAME_BEATS) - LW'(out_cnt);
   assign blen_c      = (rem_c < LW'(BURST_LEN)) ? rem_c : LW'(BURST_LEN);
   assign launch_c    = (pending != '0) & (LW'(fifo_count) >= blen_c);
   assign frame_end_c = (out_state == RESP) & BVALID &
                        (LW'(out_cnt) + cur_blen == LW'(FRAME_BEATS));
   // First burst of a frame takes the base captured at its SOF
   assign base_sel_c  = (out_cnt == '0) ? in_base : out_base;
   assign awaddr_c    = base_sel_c + ADDR_W'(wr_buf_idx) * ADDR_W'(BUF_STRIDE)
                        + ADDR_W'(out_cnt) * ADDR_W'(BYTES);
   assign next_buf_c  = (wr_buf_idx == 2'(NUM_BUF - 1)) ? 2'd0 : wr_buf_idx + 2'd1;

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) out_state <= IDLE;
      else        out_state <= out_next;
   end

   always_comb begin
      out_next = out_state;
      case (out_state)
         IDLE:    if (launch_c)         out_next = ADDR;
         ADDR:    if (AWREADY)          out_next = DATA;
         DATA:    if (WREADY && WLAST)  out_next = RESP;
         RESP:    if (BVALID)           out_next = IDLE;
         default:                       out_next = IDLE;
      endcase
   end

   // Registered AXI outputs and frame bookkeeping
   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         AWVALID      <= 1'b0;
         AWADDR       <= '0;
         AWLEN        <= '0;
         WVALID       <= 1'b0;
         WLAST        <= 1'b0;
         cur_blen     <= '0;
         beat_cnt     <= '0;
         out_cnt      <= '0;
         out_base     <= '0;
         pending      <= '0;
         wr_buf_idx   <= '0;
         last_buf_idx <= '0;
         frame_valid  <= 1'b0;
         frame_done   <= 1'b0;
         bresp_err    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         pending    <= pending + PEND_W'(sof_start_c) - PEND_W'(frame_end_c);
         case (out_state)
            IDLE: if (launch_c) begin
               AWVALID  <= 1'b1;
               AWADDR   <= awaddr_c;
               AWLEN    <= 8'(blen_c - LW'(1));
               cur_blen <= blen_c;
               if (out_cnt == '0) out_base <= in_base;
            end
            ADDR: if (AWREADY) begin
               AWVALID  <= 1'b0;
               WVALID   <= 1'b1;
               WLAST    <= (cur_blen == LW'(1));
               beat_cnt <= '0;
            end
            DATA: if (WREADY) begin
               beat_cnt <= beat_cnt + LW'(1);
               if (WLAST) begin
                  WVALID <= 1'b0;
                  WLAST  <= 1'b0;
               end else begin
                  WLAST <= (beat_cnt + LW'(2) == cur_blen);
               end
            end
            RESP: if (BVALID) begin
               if (BRESP != 2'b00) bresp_err <= 1'b1;
               if (frame_end_c) begin
                  out_cnt      <= '0;
                  frame_done   <= 1'b1;
                  last_buf_idx <= wr_buf_idx;
                  wr_buf_idx   <= next_buf_c;
                  frame_valid  <= 1'b1;
               end else begin
                  out_cnt <= out_cnt + CNT_W'(cur_blen);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_frame_buffer_writer.sv
// Directed bench for axi4_frame_buffer_writer: 10-beat frames, 4-beat bursts,
// 3-buffer ring, 8-deep FIFO. A negedge process acts as AXI B-channel slave and
// records AW/W/frame_done traffic; tests compare the records to hand values.
module tb_axi4_frame_buffer_writer;

   logic        clk_100Mhz = 1'b0;
   logic        rst_n;
   logic [31:0] base_addr;
   logic        enable;
   logic [63:0] s_data;
   logic        s_valid, s_sof, s_ready;
   logic [31:0] AWADDR;
   logic        AWVALID, AWREADY;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE, AWPROT;
   logic [1:0]  AWBURST;
   logic [3:0]  AWCACHE;
   logic [63:0] WDATA;
   logic [7:0]  WSTRB;
   logic        WVALID, WREADY, WLAST;
   logic        BVALID, BREADY;
   logic [1:0]  BRESP;
   logic [1:0]  wr_buf_idx, last_buf_idx;
   logic        frame_valid, frame_done, bresp_err, sof_err;

   int checks = 0;
   int fails  = 0;

   // monitor / B slave state
   logic [31:0] aw_addr_q[$];
   logic [7:0]  aw_len_q[$];
   logic [63:0] w_data_q[$];
   logic        w_last_q[$];
   logic [1:0]  done_idx_q[$];
   int          done_cnt = 0;
   int          aw_unstable = 0;
   int          bpend = 0;
   int          b_issued = 0;
   int          err_idx = -1;
   logic        prev_awvalid = 1'b0;
   logic [31:0] prev_awaddr = '0;
   int          acc_cnt = 0;

   always #5 clk_100Mhz = ~clk_100Mhz;

   axi4_frame_buffer_writer #(
      .ADDR_W(32), .DATA_W(64), .BURST_LEN(4), .FRAME_BYTES(80),
      .NUM_BUF(3), .BUF_STRIDE(32'h1000), .FIFO_DEPTH(8)
   ) dut (
      .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .base_addr(base_addr), .enable(enable),
      .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
      .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .wr_buf_idx(wr_buf_idx), .last_buf_idx(last_buf_idx), .frame_valid(frame_valid),
      .frame_done(frame_done), .bresp_err(bresp_err), .sof_err(sof_err)
   );

   // Negedge: answer bursts on B one cycle after WLAST, log AW/W/done traffic
   initial begin
      BVALID = 1'b0;
      BRESP  = 2'b00;
      forever begin
         @(negedge clk_100Mhz);
         if (!rst_n) begin
            BVALID = 1'b0;
            bpend  = 0;
         end else begin
            if (BVALID) BVALID = 1'b0;
            else if (bpend > 0) begin
               BVALID = 1'b1;
               BRESP  = (b_issued == err_idx) ? 2'b10 : 2'b00;
               b_issued++;
               bpend--;
            end
            if (AWVALID && AWREADY) begin
               aw_addr_q.push_back(AWADDR);
               aw_len_q.push_back(AWLEN);
            end
            if (WVALID && WREADY) begin
               w_data_q.push_back(WDATA);
               w_last_q.push_back(WLAST);
               if (WLAST) bpend++;
            end
            if (frame_done) begin
               done_cnt++;
               done_idx_q.push_back(last_buf_idx);
            end
            if (AWVALID && prev_awvalid && AWADDR != prev_awaddr) aw_unstable++;
         end
         prev_awvalid = AWVALID;
         prev_awaddr  = AWADDR;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk_100Mhz);
      @(negedge clk_100Mhz);
      rst_n = 1'b1;
      @(posedge clk_100Mhz); #1;
   endtask

   // Send n beats; sof on beat indices sa/sb (-1 = none)
   task automatic send_beats(input int n, input int sa, input int sb, input logic [63:0] v0);
      for (int i = 0; i < n; i++) begin
         logic rdy;
         int   g;
         s_valid = 1'b1;
         s_data  = v0 + 64'(i);
         s_sof   = (i == sa) || (i == sb);
         g = 0;
         do begin
            @(negedge clk_100Mhz);
            rdy = s_ready;
            @(posedge clk_100Mhz); #1;
            g++;
         end while (!rdy && g < 500);
         checks++;
         if (!rdy) begin
            fails++;
            $display("FAIL stream_accept beat %0d: s_ready stayed 0, required 1", i);
         end
         acc_cnt++;
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int g = 0;
      while (done_cnt < target && g < 600) begin
         @(posedge clk_100Mhz); #1;
         g++;
      end
      repeat (3) @(posedge clk_100Mhz);
      #1;
      checks++;
      if (done_cnt != target) begin
         fails++;
         $display("FAIL frame_done_count: got %0d, required %0d", done_cnt, target);
      end
   endtask

   // Check one frame: 3 bursts at base, data v0+i, WLAST on beats 4/8/10
   task automatic check_frame(input int a0, input int w0, input logic [31:0] base,
                              input logic [63:0] v0, input string tag);
      checks++;
      if (aw_addr_q.size() !== a0 + 3) begin
         fails++;
         $display("FAIL %s aw_count: got %0d, required %0d", tag, aw_addr_q.size() - a0, 3);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (aw_addr_q[a0+k] !== base + 32'(k * 32) ||
                aw_len_q[a0+k] !== ((k == 2) ? 8'd1 : 8'd3)) begin
               fails++;
               $display("FAIL %s aw[%0d]: got %h/%0d, required %h/%0d", tag, k,
                        aw_addr_q[a0+k], aw_len_q[a0+k], base + 32'(k * 32), (k == 2) ? 1 : 3);
            end
         end
      end
      checks++;
      if (w_data_q.size() !== w0 + 10) begin
         fails++;
         $display("FAIL %s w_count: got %0d, required 10", tag, w_data_q.size() - w0);
      end else begin
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (w_data_q[w0+i] !== v0 + 64'(i) ||
                w_last_q[w0+i] !== (i == 3 || i == 7 || i == 9)) begin
               fails++;
               $display("FAIL %s w[%0d]: got %h last %0b, required %h last %0b", tag, i,
                        w_data_q[w0+i], w_last_q[w0+i], v0 + 64'(i), (i == 3 || i == 7 || i == 9));
            end
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({AWVALID, WVALID, WLAST, frame_done, frame_valid, bresp_err, sof_err} !== 7'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b, required 0000000",
                  {AWVALID, WVALID, WLAST, frame_done, frame_valid, bresp_err, sof_err});
      end
      checks++;
      if (AWADDR !== 32'h0 || AWLEN !== 8'h0 || wr_buf_idx !== 2'd0 || last_buf_idx !== 2'd0) begin
         fails++;
         $display("FAIL reset_regs: got %h %h %0d %0d, required 0 0 0 0",
                  AWADDR, AWLEN, wr_buf_idx, last_buf_idx);
      end
      checks++;
      if (s_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_s_ready: got %b, required 1", s_ready);
      end
      checks++;
      if ({AWSIZE, AWBURST, AWCACHE, AWPROT, WSTRB, BREADY} !== {3'd3, 2'b01, 4'b0011, 3'd0, 8'hff, 1'b1}) begin
         fails++;
         $display("FAIL constants: got %0d %b %b %0d %h %b, required 3 01 0011 0 ff 1",
                  AWSIZE, AWBURST, AWCACHE, AWPROT, WSTRB, BREADY);
      end
   endtask

   task automatic test_short_burst();
      int a0 = aw_addr_q.size(), w0 = w_data_q.size(), d0 = done_cnt;
      send_beats(10, 0, -1, 64'h100);
      wait_done(d0 + 1);
      check_frame(a0, w0, 32'h1000_0000, 64'h100, "short_burst");
      checks++;
      if (last_buf_idx !== 2'd0 || wr_buf_idx !== 2'd1 || frame_valid !== 1'b1) begin
         fails++;
         $display("FAIL short_burst_idx: got last %0d wr %0d fv %b, required 0 1 1",
                  last_buf_idx, wr_buf_idx, frame_valid);
      end
   endtask

   task automatic test_ring();
      logic [31:0] exp_base [4] = '{32'h1000_0000, 32'h1000_1000, 32'h1000_2000, 32'h1000_0000};
      logic [1:0]  exp_last [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
      int a0, d0, q0;
      do_reset();
      a0 = aw_addr_q.size(); d0 = done_cnt; q0 = done_idx_q.size();
      for (int f = 0; f < 4; f++) send_beats(10, 0, -1, 64'h200 + 64'(f * 16));
      wait_done(d0 + 4);
      for (int f = 0; f < 4; f++) begin
         checks++;
         if (aw_addr_q.size() < a0 + 12 || aw_addr_q[a0 + 3*f] !== exp_base[f]) begin
            fails++;
            $display("FAIL ring_base[%0d]: got %h, required %h", f,
                     (aw_addr_q.size() > a0 + 3*f) ? aw_addr_q[a0 + 3*f] : 32'hx, exp_base[f]);
         end
         checks++;
         if (done_idx_q.size() < q0 + 4 || done_idx_q[q0 + f] !== exp_last[f]) begin
            fails++;
            $display("FAIL ring_last_idx[%0d]: got %0d, required %0d", f,
                     (done_idx_q.size() > q0 + f) ? done_idx_q[q0 + f] : 2'bx, exp_last[f]);
         end
      end
   endtask

   task automatic test_backpressure();
      int a0 = aw_addr_q.size(), w0 = w_data_q.size(), d0 = done_cnt, u0 = aw_unstable;
      acc_cnt = 0;
      AWREADY = 1'b0;
      fork
         send_beats(10, 0, -1, 64'h300);
         begin
            repeat (15) @(negedge clk_100Mhz);
            checks++;
            if (s_ready !== 1'b0 || acc_cnt !== 8) begin
               fails++;
               $display("FAIL bp_fifo_full: got s_ready %b accepted %0d, required 0 8", s_ready, acc_cnt);
            end
            checks++;
            if (AWVALID !== 1'b1 || AWADDR !== 32'h1000_1000 || AWLEN !== 8'd3) begin
               fails++;
               $display("FAIL bp_aw_hold: got %b %h %0d, required 1 10001000 3", AWVALID, AWADDR, AWLEN);
            end
            repeat (5) @(posedge clk_100Mhz);
            #1;
            AWREADY = 1'b1;
            for (int g = 0; g < 400 && done_cnt < d0 + 1; g++) begin
               WREADY = 1'($urandom_range(0, 1));
               @(posedge clk_100Mhz); #1;
            end
            WREADY = 1'b1;
         end
      join
      wait_done(d0 + 1);
      check_frame(a0, w0, 32'h1000_1000, 64'h300, "backpressure");
      checks++;
      if (aw_unstable !== u0) begin
         fails++;
         $display("FAIL bp_awaddr_stable: got %0d changes, required 0", aw_unstable - u0);
      end
   endtask

   task automatic test_resync();
      int a0 = aw_addr_q.size(), w0 = w_data_q.size(), d0 = done_cnt;
      send_beats(3, -1, -1, 64'hdead0);
      send_beats(10, 0, -1, 64'h400);
      wait_done(d0 + 1);
      check_frame(a0, w0, 32'h1000_2000, 64'h400, "resync");
      checks++;
      if (sof_err !== 1'b0) begin
         fails++;
         $display("FAIL resync_sof_err_clear: got %b, required 0", sof_err);
      end
      a0 = aw_addr_q.size(); w0 = w_data_q.size();
      send_beats(10, 0, 4, 64'h500);
      wait_done(d0 + 2);
      check_frame(a0, w0, 32'h1000_0000, 64'h500, "mid_sof");
      checks++;
      if (sof_err !== 1'b1) begin
         fails++;
         $display("FAIL mid_sof_err: got %b, required 1", sof_err);
      end
   endtask

   task automatic test_bresp_error();
      int a0 = aw_addr_q.size(), w0 = w_data_q.size(), d0 = done_cnt;
      checks++;
      if (bresp_err !== 1'b0) begin
         fails++;
         $display("FAIL bresp_err_before: got %b, required 0", bresp_err);
      end
      err_idx = b_issued + 1;
      send_beats(10, 0, -1, 64'h700);
      wait_done(d0 + 1);
      check_frame(a0, w0, 32'h1000_1000, 64'h700, "bresp");
      checks++;
      if (bresp_err !== 1'b1 || last_buf_idx !== 2'd1 || wr_buf_idx !== 2'd2) begin
         fails++;
         $display("FAIL bresp_frame: got err %b last %0d wr %0d, required 1 1 2",
                  bresp_err, last_buf_idx, wr_buf_idx);
      end
      send_beats(10, 0, -1, 64'h800);
      wait_done(d0 + 2);
      checks++;
      if (bresp_err !== 1'b1 || last_buf_idx !== 2'd2 || wr_buf_idx !== 2'd0) begin
         fails++;
         $display("FAIL bresp_sticky: got err %b last %0d wr %0d, required 1 2 0",
                  bresp_err, last_buf_idx, wr_buf_idx);
      end
   endtask

   task automatic test_reset_mid();
      int a0, w0, d0, g;
      WREADY = 1'b0;
      send_beats(6, 0, -1, 64'h900);
      g = 0;
      while (WVALID !== 1'b1 && g < 100) begin
         @(posedge clk_100Mhz); #1;
         g++;
      end
      checks++;
      if (WVALID !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_reach_data: got WVALID %b, required 1", WVALID);
      end
      @(posedge clk_100Mhz); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({AWVALID, WVALID, WLAST, frame_valid, bresp_err, sof_err, frame_done} !== 7'b0 ||
          AWADDR !== 32'h0 || AWLEN !== 8'h0 || wr_buf_idx !== 2'd0 ||
          last_buf_idx !== 2'd0 || s_ready !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_async: got flags %b addr %h len %0d wr %0d last %0d rdy %b, required 0 0 0 0 0 1",
                  {AWVALID, WVALID, WLAST, frame_valid, bresp_err, sof_err, frame_done},
                  AWADDR, AWLEN, wr_buf_idx, last_buf_idx, s_ready);
      end
      @(negedge clk_100Mhz);
      rst_n  = 1'b1;
      WREADY = 1'b1;
      @(posedge clk_100Mhz); #1;
      a0 = aw_addr_q.size(); w0 = w_data_q.size(); d0 = done_cnt;
      send_beats(10, 0, -1, 64'ha00);
      wait_done(d0 + 1);
      check_frame(a0, w0, 32'h1000_0000, 64'ha00, "after_reset");
      checks++;
      if (last_buf_idx !== 2'd0 || wr_buf_idx !== 2'd1) begin
         fails++;
         $display("FAIL after_reset_idx: got last %0d wr %0d, required 0 1", last_buf_idx, wr_buf_idx);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      base_addr = 32'h1000_0000;
      enable    = 1'b1;
      s_data    = '0;
      s_valid   = 1'b0;
      s_sof     = 1'b0;
      AWREADY   = 1'b1;
      WREADY    = 1'b1;
      test_reset();
      test_short_burst();
      test_ring();
      test_backpressure();
      test_resync();
      test_bresp_error();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
